multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath. Sits directly upstream of the ALU decoder.
- Sequences fetch, decode, execute, memory and writeback per instruction.
- Produces the 2-bit ALUOp consumed by the ALU decoder (00 add, 01 sub, 10 R-type by funct, 11 I-type by opcode), plus all datapath mux selects and write enables.
- Memory accesses use a req/ready handshake, so fetch and memory states stall until memory responds.

---
 rtl/multicycle_control_pkg.sv | 68 ++++++
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control_pkg
// Description : State encodings, datapath select encodings and MIPS opcode/funct
//               constants shared by the multicycle control FSM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package multicycle_control_pkg;

    typedef logic [3:0] state_t;

    localparam state_t c_st_fetch    = 4'd0;
    localparam state_t c_st_decode   = 4'd1;
    localparam state_t c_st_memadr   = 4'd2;
    localparam state_t c_st_memread  = 4'd3;
    localparam state_t c_st_memwb    = 4'd4;
    localparam state_t c_st_memwrite = 4'd5;
    localparam state_t c_st_rtype    = 4'd6;
    localparam state_t c_st_rwb      = 4'd7;
    localparam state_t c_st_itype    = 4'd8;
    localparam state_t c_st_iwb      = 4'd9;
    localparam state_t c_st_branch   = 4'd10;
    localparam state_t c_st_jump     = 4'd11;
    localparam state_t c_st_jal      = 4'd12;
    localparam state_t c_st_jr       = 4'd13;
    localparam state_t c_st_halt     = 4'd14;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;
    localparam logic [1:0] c_aluop_opc   = 2'b11;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;
    localparam logic [1:0] c_pcsrc_rega   = 2'b11;

    localparam logic [1:0] c_srcb_b     = 2'b00;
    localparam logic [1:0] c_srcb_four  = 2'b01;
    localparam logic [1:0] c_srcb_imm   = 2'b10;
    localparam logic [1:0] c_srcb_brimm = 2'b11;

    localparam logic [1:0] c_regdst_rt = 2'b00;
    localparam logic [1:0] c_regdst_rd = 2'b01;
    localparam logic [1:0] c_regdst_ra = 2'b10;

    localparam logic [1:0] c_mtr_aluout = 2'b00;
    localparam logic [1:0] c_mtr_mdr    = 2'b01;
    localparam logic [1:0] c_mtr_pc     = 2'b10;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_xori  = 6'h0E;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_fn_jr    = 6'h08;

endpackage

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control
// Description : Main control FSM of the multicycle MIPS datapath; sequences
//               fetch/decode/execute/memory/writeback and drives ALUOp.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit HALT_ON_BAD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       IorD,
    output logic       IRWrite,
    output logic       pc_en,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtZero,
    output logic [1:0] ALUOp,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       bad_instr,
    output logic       halted
);

    state_t r_state;
    state_t w_next;
    logic   w_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            c_st_fetch:    if (mem_ready) w_next = c_st_decode;
            c_st_decode: begin
                case (opcode)
                    c_op_lw, c_op_sw:    w_next = c_st_memadr;
                    c_op_rtype:          w_next = (funct == c_fn_jr) ? c_st_jr : c_st_rtype;
                    c_op_beq, c_op_bne:  w_next = c_st_branch;
                    c_op_addi, c_op_slti, c_op_andi, c_op_ori, c_op_xori:
                                         w_next = c_st_itype;
                    c_op_j:              w_next = c_st_jump;
                    c_op_jal:            w_next = c_st_jal;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = HALT_ON_BAD ? c_st_halt : c_st_fetch;
                    end
                endcase
            end
            c_st_memadr:   w_next = (opcode == c_op_lw) ? c_st_memread : c_st_memwrite;
            c_st_memread:  if (mem_ready) w_next = c_st_memwb;
            c_st_memwrite: if (mem_ready) w_next = c_st_fetch;
            c_st_rtype:    w_next = c_st_rwb;
            c_st_itype:    w_next = c_st_iwb;
            c_st_halt:     w_next = c_st_halt;
            default:       w_next = c_st_fetch;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        pc_en      = 1'b0;
        PCSrc      = c_pcsrc_alu;
        ALUSrcA    = 1'b0;
        ALUSrcB    = c_srcb_b;
        ExtZero    = 1'b0;
        ALUOp      = c_aluop_add;
        RegDst     = c_regdst_rt;
        MemtoReg   = c_mtr_aluout;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        bad_instr  = 1'b0;
        halted     = 1'b0;
        case (r_state)
            c_st_fetch: begin
                mem_req = 1'b1;
                ALUSrcB = c_srcb_four;
                IRWrite = mem_ready;
                pc_en   = mem_ready;
            end
            c_st_decode: begin
                ALUSrcB   = c_srcb_brimm;
                bad_instr = w_illegal;
            end
            c_st_memadr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_srcb_imm;
            end
            c_st_memread: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            c_st_memwb: begin
                MemtoReg   = c_mtr_mdr;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            c_st_memwrite: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            c_st_rtype: begin
                ALUSrcA = 1'b1;
                ALUOp   = c_aluop_funct;
            end
            c_st_rwb: begin
                RegDst     = c_regdst_rd;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            c_st_itype: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_srcb_imm;
                ALUOp   = c_aluop_opc;
                ExtZero = (opcode == c_op_andi) || (opcode == c_op_ori) || (opcode == c_op_xori);
            end
            c_st_iwb: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            c_st_branch: begin
                ALUSrcA    = 1'b1;
                ALUOp      = c_aluop_sub;
                PCSrc      = c_pcsrc_aluout;
                pc_en      = (opcode == c_op_bne) ? ~zero : zero;
                instr_done = 1'b1;
            end
            c_st_jump: begin
                PCSrc      = c_pcsrc_jump;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            // PC and $31 update on the same edge, so the link value is still PC+4.
            c_st_jal: begin
                PCSrc      = c_pcsrc_jump;
                pc_en      = 1'b1;
                RegDst     = c_regdst_ra;
                MemtoReg   = c_mtr_pc;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            c_st_jr: begin
                PCSrc      = c_pcsrc_rega;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            c_st_halt: halted = 1'b1;
            default: ;
        endcase
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            IRWrite    = 1'b0;
            pc_en      = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
            bad_instr  = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : tb_multicycle_control
// Description : Directed, table-driven bench for multicycle_control with both
//               HALT_ON_BAD settings side by side.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       irwrite;
        logic       pc_en;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extzero;
        logic [1:0] aluop;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       regwrite;
        logic       instr_done;
        logic       bad_instr;
        logic       halted;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    outs_t o0, o1;
    int    errors = 0;
    int    checks = 0;
    vec_t  vecs[$];

    always #5 clk = ~clk;

    multicycle_control #(.HALT_ON_BAD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(o0.mem_req), .mem_we(o0.mem_we), .IorD(o0.iord),
        .IRWrite(o0.irwrite), .pc_en(o0.pc_en), .PCSrc(o0.pcsrc), .ALUSrcA(o0.alusrca),
        .ALUSrcB(o0.alusrcb), .ExtZero(o0.extzero), .ALUOp(o0.aluop), .RegDst(o0.regdst),
        .MemtoReg(o0.memtoreg), .RegWrite(o0.regwrite), .instr_done(o0.instr_done),
        .bad_instr(o0.bad_instr), .halted(o0.halted)
    );

    multicycle_control #(.HALT_ON_BAD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(o1.mem_req), .mem_we(o1.mem_we), .IorD(o1.iord),
        .IRWrite(o1.irwrite), .pc_en(o1.pc_en), .PCSrc(o1.pcsrc), .ALUSrcA(o1.alusrca),
        .ALUSrcB(o1.alusrcb), .ExtZero(o1.extzero), .ALUOp(o1.aluop), .RegDst(o1.regdst),
        .MemtoReg(o1.memtoreg), .RegWrite(o1.regwrite), .instr_done(o1.instr_done),
        .bad_instr(o1.bad_instr), .halted(o1.halted)
    );

    // Hand-derived output patterns for each control state.
    function automatic outs_t o_fetch(input logic rdy);
        outs_t t = '0;
        t.mem_req = 1'b1; t.alusrcb = 2'b01; t.irwrite = rdy; t.pc_en = rdy;
        return t;
    endfunction
    function automatic outs_t o_fetch_rst();
        outs_t t = '0;
        t.alusrcb = 2'b01;
        return t;
    endfunction
    function automatic outs_t o_decode();
        outs_t t = '0;
        t.alusrcb = 2'b11;
        return t;
    endfunction
    function automatic outs_t o_bad();
        outs_t t = '0;
        t.alusrcb = 2'b11; t.bad_instr = 1'b1;
        return t;
    endfunction
    function automatic outs_t o_memadr();
        outs_t t = '0;
        t.alusrca = 1'b1; t.alusrcb = 2'b10;
        return t;
    endfunction
    function automatic outs_t o_memread();
        outs_t t = '0;
        t.mem_req = 1'b1; t.iord = 1'b1;
        return t;
    endfunction
    function automatic outs_t o_memwb();
        outs_t t = '0;
        t.memtoreg = 2'b01; t.regwrite = 1'b1; t.instr_done = 1'b1;
        return t;
    endfunction
    function automatic outs_t o_memwrite(input logic rdy);
        outs_t t = '0;
        t.mem_req = 1'b1; t.mem_we = 1'b1; t.iord = 1'b1; t.instr_done = rdy;
        return t;
    endfunction
    function automatic outs_t o_rtype();
        outs_t t = '0;
        t.alusrca = 1'b1; t.aluop = 2'b10;
        return t;
    endfunction
    function automatic outs_t o_rwb();
        outs_t t = '0;
        t.regdst = 2'b01; t.regwrite = 1'b1; t.instr_done = 1'b1;
        return t;
    endfunction
    function automatic outs_t o_itype(input logic ext);
        outs_t t = '0;
        t.alusrca = 1'b1; t.alusrcb = 2'b10; t.aluop = 2'b11; t.extzero = ext;
        return t;
    endfunction
    function automatic outs_t o_iwb();
        outs_t t = '0;
        t.regwrite = 1'b1; t.instr_done = 1'b1;
        return t;
    endfunction
    function automatic outs_t o_branch(input logic pcen);
        outs_t t = '0;
        t.alusrca = 1'b1; t.aluop = 2'b01; t.pcsrc = 2'b01; t.pc_en = pcen; t.instr_done = 1'b1;
        return t;
    endfunction
    function automatic outs_t o_jump();
        outs_t t = '0;
        t.pcsrc = 2'b10; t.pc_en = 1'b1; t.instr_done = 1'b1;
        return t;
    endfunction
    function automatic outs_t o_jal();
        outs_t t = '0;
        t.pcsrc = 2'b10; t.pc_en = 1'b1; t.regdst = 2'b10; t.memtoreg = 2'b10;
        t.regwrite = 1'b1; t.instr_done = 1'b1;
        return t;
    endfunction
    function automatic outs_t o_jr();
        outs_t t = '0;
        t.pcsrc = 2'b11; t.pc_en = 1'b1; t.instr_done = 1'b1;
        return t;
    endfunction
    function automatic outs_t o_halt();
        outs_t t = '0;
        t.halted = 1'b1;
        return t;
    endfunction

    function automatic void add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic rdy, input outs_t e);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy,
                        input logic c0, input outs_t e0,
                        input logic c1, input outs_t e1, input string nm);
        @(negedge clk);
        reset = r; opcode = op; funct = fn; zero = z; mem_ready = rdy;
        #1;
        if (c0) begin
            checks++;
            if (o0 !== e0) begin
                errors++;
                $display("FAIL %s dut0: got %h want %h", nm, o0, e0);
            end
        end
        if (c1) begin
            checks++;
            if (o1 !== e1) begin
                errors++;
                $display("FAIL %s dut1: got %h want %h", nm, o1, e1);
            end
        end
    endtask

    initial begin
        add(1, 6'h00, 6'h00, 0, 1, o_fetch_rst());
        add(1, 6'h00, 6'h00, 0, 1, o_fetch_rst());
        // lw with two wait cycles in FETCH and MEMREAD: 9 cycles
        add(0, 6'h23, 6'h00, 0, 0, o_fetch(0));
        add(0, 6'h23, 6'h00, 0, 0, o_fetch(0));
        add(0, 6'h23, 6'h00, 0, 1, o_fetch(1));
        add(0, 6'h23, 6'h00, 0, 1, o_decode());
        add(0, 6'h23, 6'h00, 0, 0, o_memadr());
        add(0, 6'h23, 6'h00, 0, 0, o_memread());
        add(0, 6'h23, 6'h00, 0, 0, o_memread());
        add(0, 6'h23, 6'h00, 0, 1, o_memread());
        add(0, 6'h23, 6'h00, 0, 1, o_memwb());
        // sll, addi, andi
        add(0, 6'h00, 6'h00, 0, 1, o_fetch(1));
        add(0, 6'h00, 6'h00, 0, 1, o_decode());
        add(0, 6'h00, 6'h00, 0, 1, o_rtype());
        add(0, 6'h00, 6'h00, 0, 1, o_rwb());
        add(0, 6'h08, 6'h00, 0, 1, o_fetch(1));
        add(0, 6'h08, 6'h00, 0, 1, o_decode());
        add(0, 6'h08, 6'h00, 0, 1, o_itype(0));
        add(0, 6'h08, 6'h00, 0, 1, o_iwb());
        add(0, 6'h0C, 6'h00, 0, 1, o_fetch(1));
        add(0, 6'h0C, 6'h00, 0, 1, o_decode());
        add(0, 6'h0C, 6'h00, 0, 1, o_itype(1));
        add(0, 6'h0C, 6'h00, 0, 1, o_iwb());
        // beq z=1, bne z=1, bne z=0
        add(0, 6'h04, 6'h00, 1, 1, o_fetch(1));
        add(0, 6'h04, 6'h00, 1, 1, o_decode());
        add(0, 6'h04, 6'h00, 1, 1, o_branch(1));
        add(0, 6'h05, 6'h00, 1, 1, o_fetch(1));
        add(0, 6'h05, 6'h00, 1, 1, o_decode());
        add(0, 6'h05, 6'h00, 1, 1, o_branch(0));
        add(0, 6'h05, 6'h00, 0, 1, o_fetch(1));
        add(0, 6'h05, 6'h00, 0, 1, o_decode());
        add(0, 6'h05, 6'h00, 0, 1, o_branch(1));
        // jal, jr, j
        add(0, 6'h03, 6'h00, 0, 1, o_fetch(1));
        add(0, 6'h03, 6'h00, 0, 1, o_decode());
        add(0, 6'h03, 6'h00, 0, 1, o_jal());
        add(0, 6'h00, 6'h08, 0, 1, o_fetch(1));
        add(0, 6'h00, 6'h08, 0, 1, o_decode());
        add(0, 6'h00, 6'h08, 0, 1, o_jr());
        add(0, 6'h02, 6'h00, 0, 1, o_fetch(1));
        add(0, 6'h02, 6'h00, 0, 1, o_decode());
        add(0, 6'h02, 6'h00, 0, 1, o_jump());
        // sw with one wait cycle
        add(0, 6'h2B, 6'h00, 0, 1, o_fetch(1));
        add(0, 6'h2B, 6'h00, 0, 1, o_decode());
        add(0, 6'h2B, 6'h00, 0, 1, o_memadr());
        add(0, 6'h2B, 6'h00, 0, 0, o_memwrite(0));
        add(0, 6'h2B, 6'h00, 0, 1, o_memwrite(1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy,
                 1'b1, vecs[i].exp, 1'b1, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Illegal opcode: dut0 recovers to FETCH, dut1 halts until reset.
        step(0, 6'h3F, 6'h00, 0, 1, 1'b1, o_fetch(1), 1'b1, o_fetch(1), "bad_fetch");
        step(0, 6'h3F, 6'h00, 0, 1, 1'b1, o_bad(),    1'b1, o_bad(),    "bad_decode");
        step(0, 6'h23, 6'h00, 0, 1, 1'b1, o_fetch(1), 1'b1, o_halt(),   "bad_next");
        for (int i = 0; i < 4; i++) begin
            step(0, 6'h23, 6'h00, 0, 1, 1'b0, '0, 1'b1, o_halt(), $sformatf("halt_hold%0d", i));
        end
        step(1, 6'h23, 6'h00, 0, 1, 1'b0, '0, 1'b1, o_halt(), "halt_in_reset");
        step(0, 6'h23, 6'h00, 0, 0, 1'b1, o_fetch(0), 1'b1, o_fetch(0), "halt_exit");

        // Reset while sw waits on memory drops the request.
        step(0, 6'h2B, 6'h00, 0, 1, 1'b1, o_fetch(1),     1'b1, o_fetch(1),     "swr_fetch");
        step(0, 6'h2B, 6'h00, 0, 1, 1'b1, o_decode(),     1'b1, o_decode(),     "swr_decode");
        step(0, 6'h2B, 6'h00, 0, 1, 1'b1, o_memadr(),     1'b1, o_memadr(),     "swr_memadr");
        step(0, 6'h2B, 6'h00, 0, 0, 1'b1, o_memwrite(0),  1'b1, o_memwrite(0),  "swr_wait");
        begin
            outs_t g;
            g = '0;
            g.iord = 1'b1;
            step(1, 6'h2B, 6'h00, 0, 0, 1'b1, g, 1'b1, g, "swr_reset_gated");
        end
        step(0, 6'h2B, 6'h00, 0, 0, 1'b1, o_fetch(0), 1'b1, o_fetch(0), "swr_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
